// File: rtl/xcr_hub.sv
// xcr_hub: extended-control-register hub between the CPU's 8-bit control
// register port and up to 15 XCR slave slots. Registered, ready-handshaked
// access path with slave wait states, supervisor-only slot protection and a
// built-in fault status slot at 0xF0-0xFF. Faults raise xcp_bus_fault.
//
// Build option: define XCR_HUB_TIMEOUT_EN to include the bus-timeout
// watchdog (ERR_STAT bit2). Without it ACCESS waits for s_rdy indefinitely.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for cr_cs; decodes the request on the sampling edge
// ST_ACCESS | slave selected, waiting for s_rdy of that slot (or timeout)
// ST_DONE   | cr_rdy/cr_err presented for one cycle
module xcr_hub #(
    parameter int                N_SLOT    = 4,
    parameter logic [N_SLOT-1:0] SLOT_EN   = 4'b0011,
    parameter logic [N_SLOT-1:0] PRIV_MASK = 4'b0010,
    parameter int                TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cr_cs,
    input  logic                cr_we,
    input  logic [7:0]          cr_adr,
    input  logic [7:0]          cr_din,
    output logic [7:0]          cr_dout,
    output logic                cr_rdy,
    output logic                cr_err,
    input  logic                supervisor_mode,
    output logic                xcp_bus_fault,
    output logic [N_SLOT-1:0]   s_cs,
    output logic                s_we,
    output logic [3:0]          s_adr,
    output logic [7:0]          s_din,
    input  logic [N_SLOT*8-1:0] s_dout,
    input  logic [N_SLOT-1:0]   s_rdy
);

    // Slot masks widened to the full 16-slot decode space; slots at or above
    // N_SLOT (including 0xF) read as disabled / unprivileged here.
    localparam logic [15:0] EN_EXT   = 16'(SLOT_EN);
    localparam logic [15:0] PRIV_EXT = 16'(PRIV_MASK);

    localparam int B_UNMAP = 0;
    localparam int B_PRIV  = 1;
    localparam int B_TMO   = 2;

`ifdef XCR_HUB_TIMEOUT_EN
    localparam logic [2:0] STAT_MASK = 3'b111;
`else
    localparam logic [2:0] STAT_MASK = 3'b011;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t state, state_d;

    logic [7:0]        adr_q, adr_d;
    logic [7:0]        din_q, din_d;
    logic              we_q, we_d;
    logic [N_SLOT-1:0] cs_d;
    logic              swe_d;
    logic [7:0]        dout_d;
    logic              rdy_d, err_d;
    logic [2:0]        err_stat, err_stat_d, stat_set, stat_clr;
    logic [7:0]        err_adr, err_adr_d;
    logic [3:0]        slot;
    logic              is_stat, mapped, priv;
    logic [7:0]        stat_rd, sel_dout;
    logic              rdy_hit, timeout_hit;

    assign slot    = cr_adr[7:4];
    assign is_stat = (slot == 4'hF);
    assign mapped  = EN_EXT[slot];
    assign priv    = is_stat | PRIV_EXT[slot];

    // s_cs is one-hot for the active access, so it also masks off the
    // ready and read data of every non-selected slot.
    assign rdy_hit = |(s_rdy & s_cs);

    assign s_adr = adr_q[3:0];
    assign s_din = din_q;

    // Read data of the selected slave.
    always_comb begin
        sel_dout = '0;
        for (int k = 0; k < N_SLOT; k++) begin
            if (s_cs[k]) sel_dout = sel_dout | s_dout[8*k +: 8];
        end
    end

    // Status slot read mux.
    always_comb begin
        stat_rd = 8'h00;
        case (cr_adr[3:0])
            4'h0:    stat_rd = {5'b0, err_stat};
            4'h1:    stat_rd = err_adr;
            4'h2:    stat_rd = 8'(N_SLOT);
            4'h3:    stat_rd = EN_EXT[7:0];
            default: stat_rd = 8'h00;
        endcase
    end

`ifdef XCR_HUB_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

    logic [7:0] wait_cnt;

    // Watchdog: reloaded while idle, counts down through ACCESS, fires at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= TMO_LOAD;
        end else if (state == ST_ACCESS && wait_cnt != 8'd0) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

    assign timeout_hit = (wait_cnt == 8'd0);
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    // Sticky fault bits: a set in the same cycle as a W1C clear wins.
    assign err_stat_d = ((err_stat & ~stat_clr) | stat_set) & STAT_MASK;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        adr_d     = adr_q;
        we_d      = we_q;
        din_d     = din_q;
        cs_d      = s_cs;
        swe_d     = s_we;
        dout_d    = cr_dout;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        stat_set  = '0;
        stat_clr  = '0;
        err_adr_d = err_adr;
        case (state)
            ST_IDLE: begin
                if (cr_cs) begin
                    adr_d = cr_adr;
                    we_d  = cr_we;
                    din_d = cr_din;
                    if (is_stat && supervisor_mode) begin
                        state_d = ST_DONE;
                        rdy_d   = 1'b1;
                        if (!cr_we) begin
                            dout_d = stat_rd;
                        end else if (cr_adr[3:0] == 4'h0) begin
                            stat_clr = cr_din[2:0];
                        end
                    end else if (!is_stat && !mapped) begin
                        state_d           = ST_DONE;
                        rdy_d             = 1'b1;
                        err_d             = 1'b1;
                        stat_set[B_UNMAP] = 1'b1;
                        err_adr_d         = cr_adr;
                        if (!cr_we) dout_d = 8'hFF;
                    end else if (priv && !supervisor_mode) begin
                        state_d          = ST_DONE;
                        rdy_d            = 1'b1;
                        err_d            = 1'b1;
                        stat_set[B_PRIV] = 1'b1;
                        err_adr_d        = cr_adr;
                        if (!cr_we) dout_d = 8'hFF;
                    end else begin
                        state_d = ST_ACCESS;
                        swe_d   = cr_we;
                        for (int k = 0; k < N_SLOT; k++) begin
                            cs_d[k] = (slot == 4'(k));
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (rdy_hit) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    cs_d    = '0;
                    swe_d   = 1'b0;
                    if (!we_q) dout_d = sel_dout;
                end else if (timeout_hit) begin
                    state_d         = ST_DONE;
                    rdy_d           = 1'b1;
                    err_d           = 1'b1;
                    cs_d            = '0;
                    swe_d           = 1'b0;
                    stat_set[B_TMO] = 1'b1;
                    err_adr_d       = adr_q;
                    if (!we_q) dout_d = 8'hFF;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Request latches, registered outputs and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q         <= '0;
            we_q          <= 1'b0;
            din_q         <= '0;
            s_cs          <= '0;
            s_we          <= 1'b0;
            cr_dout       <= '0;
            cr_rdy        <= 1'b0;
            cr_err        <= 1'b0;
            xcp_bus_fault <= 1'b0;
            err_stat      <= '0;
            err_adr       <= '0;
        end else begin
            adr_q         <= adr_d;
            we_q          <= we_d;
            din_q         <= din_d;
            s_cs          <= cs_d;
            s_we          <= swe_d;
            cr_dout       <= dout_d;
            cr_rdy        <= rdy_d;
            cr_err        <= err_d;
            xcp_bus_fault <= rdy_d & err_d;
            err_stat      <= err_stat_d;
            err_adr       <= err_adr_d;
        end
    end

endmodule
